// File: rtl/sprite_pkg.sv
// sprite_pkg -- shared types and constants for the sprite compositor.
// Holds the 2-bit pixel-code enum, the rgb24 colour type, the default
// palette, the default geometry, and the helpers that define the sprite
// artwork and the code-to-colour mapping.
// No ports (package).
package sprite_pkg;

  localparam int SPR_SIZE_DEF = 16;
  localparam int COORD_W_DEF  = 10;

  typedef logic [23:0] rgb24;

  typedef enum logic [1:0] {
    PIX_CLEAR   = 2'd0,
    PIX_BODY    = 2'd1,
    PIX_EYE     = 2'd2,
    PIX_OUTLINE = 2'd3
  } pix_code_e;

  localparam rgb24 PAL_SPR0    = 24'hFFFF00;
  localparam rgb24 PAL_SPR1    = 24'hFF0000;
  localparam rgb24 PAL_SPR2    = 24'h00FF00;
  localparam rgb24 PAL_SPR3    = 24'h00FFFF;
  localparam rgb24 PAL_OTHER   = 24'hFF00FF;
  localparam rgb24 PAL_EYE     = 24'hFFFFFF;
  localparam rgb24 PAL_OUTLINE = 24'h000000;

  // Body colour of a given sprite channel.
  function automatic rgb24 body_colour(input logic [2:0] idx);
    rgb24 c;
    case (idx)
      3'd0:    c = PAL_SPR0;
      3'd1:    c = PAL_SPR1;
      3'd2:    c = PAL_SPR2;
      3'd3:    c = PAL_SPR3;
      default: c = PAL_OTHER;
    endcase
    return c;
  endfunction

  // Colour for an opaque pixel code of sprite idx.
  function automatic rgb24 code_colour(input pix_code_e code, input logic [2:0] idx);
    rgb24 c;
    case (code)
      PIX_BODY:    c = body_colour(idx);
      PIX_EYE:     c = PAL_EYE;
      PIX_OUTLINE: c = PAL_OUTLINE;
      default:     c = PAL_OUTLINE;
    endcase
    return c;
  endfunction

  // Sprite artwork. Image 0: outlined face with two eyes on row 2.
  // Image 1: image 0 with the left half transparent. Image 2: solid body.
  // Image 3: fully transparent.
  function automatic pix_code_e sprite_code(input logic [1:0] img, input logic [7:0] lx,
                                            input logic [7:0] ly, input logic [7:0] size);
    logic      border;
    logic      eye;
    logic      left;
    pix_code_e face;
    pix_code_e c;
    border = (lx == 8'd0) || (ly == 8'd0) || (lx == size - 8'd1) || (ly == size - 8'd1);
    eye    = (ly == 8'd2) && ((lx == 8'd2) || (lx == size - 8'd3));
    left   = lx < (size >> 1);
    if (border) begin
      face = PIX_OUTLINE;
    end else if (eye) begin
      face = PIX_EYE;
    end else begin
      face = PIX_BODY;
    end
    case (img)
      2'd0:    c = face;
      2'd1:    c = left ? PIX_CLEAR : face;
      2'd2:    c = PIX_BODY;
      default: c = PIX_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if -- pixel-stream and sprite-state bundle.
// master: drives DrawX/DrawY/blank/frame_start/bg_rgb and sprite state
//         (spr_x, spr_y, spr_en, spr_img); receives Red/Green/Blue,
//         blank_out, collide, collide_valid.
// slave:  the compositor side, directions reversed.
interface sprite_compositor_if
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = COORD_W_DEF
);
  logic [COORD_W-1:0]                  DrawX;
  logic [COORD_W-1:0]                  DrawY;
  logic                                blank;
  logic                                frame_start;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] spr_x;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] spr_y;
  logic [NUM_SPRITES-1:0]              spr_en;
  logic [NUM_SPRITES-1:0][1:0]         spr_img;
  rgb24                                bg_rgb;
  logic [7:0]                          Red;
  logic [7:0]                          Green;
  logic [7:0]                          Blue;
  logic                                blank_out;
  logic [NUM_SPRITES-2:0]              collide;
  logic                                collide_valid;

  modport master (
    output DrawX, DrawY, blank, frame_start, spr_x, spr_y, spr_en, spr_img, bg_rgb,
    input  Red, Green, Blue, blank_out, collide, collide_valid
  );

  modport slave (
    input  DrawX, DrawY, blank, frame_start, spr_x, spr_y, spr_en, spr_img, bg_rgb,
    output Red, Green, Blue, blank_out, collide, collide_valid
  );
endinterface

// File: rtl/sprite_rom.sv
// sprite_rom -- registered sprite artwork ROM, one read per cycle.
// Ports: clk, rst_n (async active-low), addr = {img, local_y, local_x},
//        code = 2-bit pixel code, valid one cycle after addr.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE = SPR_SIZE_DEF,
  localparam int LOC_W   = $clog2(SPR_SIZE),
  localparam int ADDR_W  = 2 + 2 * LOC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output pix_code_e         code
);

  logic [1:0]       img_s;
  logic [LOC_W-1:0] ly_s;
  logic [LOC_W-1:0] lx_s;
  pix_code_e        code_s;

  assign img_s  = addr[ADDR_W-1 -: 2];
  assign ly_s   = addr[2*LOC_W-1 -: LOC_W];
  assign lx_s   = addr[LOC_W-1:0];
  assign code_s = sprite_code(img_s, 8'(lx_s), 8'(ly_s), 8'(SPR_SIZE));

  // ROM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= PIX_CLEAR;
    end else begin
      code <= code_s;
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor -- three-stage sprite overlay on a background pixel stream.
// Stage 1: per-sprite hit test and ROM address. Stage 2: ROM codes.
// Stage 3: priority select (lowest opaque index wins), blanking, output reg.
// Ports: Clk, Reset_n (async active-low), bus (sprite_compositor_if.slave).
// Build option: define SPRITE_COLLISION_EN to include player-vs-sprite
// collision tracking; otherwise collide/collide_valid are tied to 0.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_SIZE    = SPR_SIZE_DEF,
  parameter int COORD_W     = COORD_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  sprite_compositor_if.slave bus
);

  localparam int LOC_W  = $clog2(SPR_SIZE);
  localparam int ADDR_W = 2 + 2 * LOC_W;
  localparam logic [COORD_W:0] SIZE_EXT = (COORD_W + 1)'(SPR_SIZE);

  logic [NUM_SPRITES-1:0][COORD_W:0]  dx_s;
  logic [NUM_SPRITES-1:0][COORD_W:0]  dy_s;
  logic [NUM_SPRITES-1:0]             hit_s;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0] addr_s;

  logic [NUM_SPRITES-1:0]             hit_s1_r;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0] addr_s1_r;
  rgb24                               bg_s1_r;
  logic                               blank_s1_r;

  pix_code_e                          code_s2 [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]             hit_s2_r;
  rgb24                               bg_s2_r;
  logic                               blank_s2_r;

  logic [NUM_SPRITES-1:0]             opaque_s;
  rgb24                               pix_s;
  rgb24                               rgb_r;
  logic                               blank_out_r;

  // Differences are taken one bit wider than the screen so a sprite to the
  // right of / below the pixel goes "negative" (MSB set) instead of wrapping;
  // that alone clips sprites at the right and bottom screen edges.
  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
    assign dx_s[k]   = {1'b0, bus.DrawX} - {1'b0, bus.spr_x[k]};
    assign dy_s[k]   = {1'b0, bus.DrawY} - {1'b0, bus.spr_y[k]};
    assign hit_s[k]  = bus.spr_en[k] && (dx_s[k] < SIZE_EXT) && (dy_s[k] < SIZE_EXT);
    assign addr_s[k] = {bus.spr_img[k], dy_s[k][LOC_W-1:0], dx_s[k][LOC_W-1:0]};

    sprite_rom #(.SPR_SIZE(SPR_SIZE)) u_rom (
      .clk   (Clk),
      .rst_n (Reset_n),
      .addr  (addr_s1_r[k]),
      .code  (code_s2[k])
    );

    assign opaque_s[k] = hit_s2_r[k] && (code_s2[k] != PIX_CLEAR);
  end

  // Stage 1 register: hit flags, ROM addresses and the background stream.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_s1_r   <= {NUM_SPRITES{1'b0}};
      addr_s1_r  <= {(NUM_SPRITES * ADDR_W){1'b0}};
      bg_s1_r    <= 24'h000000;
      blank_s1_r <= 1'b0;
    end else begin
      hit_s1_r   <= hit_s;
      addr_s1_r  <= addr_s;
      bg_s1_r    <= bus.bg_rgb;
      blank_s1_r <= bus.blank;
    end
  end

  // Stage 2 register: hit flags and background travel alongside the ROM read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_s2_r   <= {NUM_SPRITES{1'b0}};
      bg_s2_r    <= 24'h000000;
      blank_s2_r <= 1'b0;
    end else begin
      hit_s2_r   <= hit_s1_r;
      bg_s2_r    <= bg_s1_r;
      blank_s2_r <= blank_s1_r;
    end
  end

  // Stage 3 select: scanning from the highest index down lets the lowest
  // opaque index overwrite last, so it wins; blanking forces black.
  always_comb begin
    pix_s = bg_s2_r;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (opaque_s[k]) begin
        pix_s = code_colour(code_s2[k], 3'(k));
      end else begin
        pix_s = pix_s;
      end
    end
    if (!blank_s2_r) begin
      pix_s = 24'h000000;
    end else begin
      pix_s = pix_s;
    end
  end

  // Output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_r       <= 24'h000000;
      blank_out_r <= 1'b0;
    end else begin
      rgb_r       <= pix_s;
      blank_out_r <= blank_s2_r;
    end
  end

  assign bus.Red       = rgb_r[23:16];
  assign bus.Green     = rgb_r[15:8];
  assign bus.Blue      = rgb_r[7:0];
  assign bus.blank_out = blank_out_r;

`ifdef SPRITE_COLLISION_EN
  logic                   fs_s1_r;
  logic                   fs_s2_r;
  logic [NUM_SPRITES-2:0] coll_now_s;
  logic [NUM_SPRITES-2:0] sticky_r;
  logic [NUM_SPRITES-2:0] collide_r;
  logic                   collide_valid_r;

  for (genvar k = 1; k < NUM_SPRITES; k++) begin : g_coll
    assign coll_now_s[k-1] = opaque_s[0] && opaque_s[k] && blank_s2_r;
  end

  // frame_start is delayed to stage 2 so the frame boundary lines up with
  // the pixel it was issued with.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_s1_r <= 1'b0;
      fs_s2_r <= 1'b0;
    end else begin
      fs_s1_r <= bus.frame_start;
      fs_s2_r <= fs_s1_r;
    end
  end

  // Sticky collision bits; at a frame boundary they are published and the
  // boundary pixel's own collision seeds the new frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sticky_r        <= {(NUM_SPRITES - 1){1'b0}};
      collide_r       <= {(NUM_SPRITES - 1){1'b0}};
      collide_valid_r <= 1'b0;
    end else if (fs_s2_r) begin
      collide_r       <= sticky_r;
      collide_valid_r <= 1'b1;
      sticky_r        <= coll_now_s;
    end else begin
      collide_valid_r <= 1'b0;
      sticky_r        <= sticky_r | coll_now_s;
    end
  end

  assign bus.collide       = collide_r;
  assign bus.collide_valid = collide_valid_r;
`else
  assign bus.collide       = {(NUM_SPRITES - 1){1'b0}};
  assign bus.collide_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor -- directed self-checking bench for sprite_compositor.
// Expected colours are hand-derived from the sprite artwork: image 0 is an
// outlined 16x16 face (eyes at local (2,2) and (13,2)), image 1 is image 0
// with columns 0..7 transparent, image 2 is solid body.
// Collision expectations depend on SPRITE_COLLISION_EN.
module tb_sprite_compositor;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sprite_compositor_if #(.NUM_SPRITES(4), .COORD_W(10)) bus ();

  sprite_compositor #(.NUM_SPRITES(4), .SPR_SIZE(16), .COORD_W(10)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  function automatic rgb24 rgb_now();
    return {bus.Red, bus.Green, bus.Blue};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic b, input rgb24 bg, input logic fs);
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.blank       = b;
    bus.bg_rgb      = bg;
    bus.frame_start = fs;
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 24'h000000, 1'b0);
  endtask

  // One pixel followed by idle, stepping until its colour is at the outputs.
  task automatic pixel(input int x, input int y, input logic b, input rgb24 bg, input logic fs);
    drive(x, y, b, bg, fs);
    step();
    idle();
    step();
    step();
  endtask

  task automatic set_spr(input int k, input int x, input int y, input logic en, input logic [1:0] img);
    bus.spr_x[k]   = 10'(x);
    bus.spr_y[k]   = 10'(y);
    bus.spr_en[k]  = en;
    bus.spr_img[k] = img;
  endtask

  task automatic test_reset();
    idle();
    for (int k = 0; k < 4; k++) set_spr(k, 0, 0, 1'b0, 2'd0);
    step();
    step();
    vectors++;
    if (rgb_now() !== 24'h000000 || bus.blank_out !== 1'b0) begin
      $display("FAIL reset_out: got rgb=%h blank_out=%b, want 000000/0", rgb_now(), bus.blank_out);
      errors++;
    end
    vectors++;
    if (bus.collide !== 3'b000 || bus.collide_valid !== 1'b0) begin
      $display("FAIL reset_collide: got %b/%b, want 000/0", bus.collide, bus.collide_valid);
      errors++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    set_spr(0, 100, 100, 1'b1, 2'd0);
    drive(104, 104, 1'b1, 24'h123456, 1'b0);
    step();
    idle();
    step();
    vectors++;
    if (rgb_now() !== 24'h000000) begin
      $display("FAIL latency_early: got %h after 2 cycles, want 000000", rgb_now());
      errors++;
    end
    step();
    vectors++;
    if (rgb_now() !== 24'hFFFF00 || bus.blank_out !== 1'b1) begin
      $display("FAIL latency_3: got %h/%b, want FFFF00/1", rgb_now(), bus.blank_out);
      errors++;
    end
    step();
    vectors++;
    if (rgb_now() !== 24'h000000) begin
      $display("FAIL latency_after: got %h, want 000000", rgb_now());
      errors++;
    end
  endtask

  task automatic test_palette();
    set_spr(3, 400, 300, 1'b1, 2'd2);
    pixel(100, 100, 1'b1, 24'h123456, 1'b0);
    vectors++;
    if (rgb_now() !== 24'h000000) begin
      $display("FAIL outline: got %h, want 000000", rgb_now());
      errors++;
    end
    pixel(102, 102, 1'b1, 24'h123456, 1'b0);
    vectors++;
    if (rgb_now() !== 24'hFFFFFF) begin
      $display("FAIL eye_left: got %h, want FFFFFF", rgb_now());
      errors++;
    end
    pixel(113, 102, 1'b1, 24'h123456, 1'b0);
    vectors++;
    if (rgb_now() !== 24'hFFFFFF) begin
      $display("FAIL eye_right: got %h, want FFFFFF", rgb_now());
      errors++;
    end
    pixel(401, 301, 1'b1, 24'h123456, 1'b0);
    vectors++;
    if (rgb_now() !== 24'h00FFFF) begin
      $display("FAIL spr3_body: got %h, want 00FFFF", rgb_now());
      errors++;
    end
    pixel(200, 200, 1'b1, 24'h0A0B0C, 1'b0);
    vectors++;
    if (rgb_now() !== 24'h0A0B0C) begin
      $display("FAIL background: got %h, want 0A0B0C", rgb_now());
      errors++;
    end
    set_spr(3, 0, 0, 1'b0, 2'd0);
  endtask

  task automatic test_priority();
    set_spr(0, 50, 50, 1'b1, 2'd0);
    set_spr(1, 50, 50, 1'b1, 2'd0);
    pixel(55, 55, 1'b1, 24'h111111, 1'b0);
    vectors++;
    if (rgb_now() !== 24'hFFFF00) begin
      $display("FAIL prio_both: got %h, want FFFF00", rgb_now());
      errors++;
    end
    set_spr(0, 50, 50, 1'b0, 2'd0);
    pixel(55, 55, 1'b1, 24'h111111, 1'b0);
    vectors++;
    if (rgb_now() !== 24'hFF0000) begin
      $display("FAIL prio_spr0_off: got %h, want FF0000", rgb_now());
      errors++;
    end
    set_spr(0, 50, 50, 1'b1, 2'd1);
    pixel(54, 55, 1'b1, 24'h111111, 1'b0);
    vectors++;
    if (rgb_now() !== 24'hFF0000) begin
      $display("FAIL prio_transparent: got %h, want FF0000", rgb_now());
      errors++;
    end
    pixel(60, 55, 1'b1, 24'h111111, 1'b0);
    vectors++;
    if (rgb_now() !== 24'hFFFF00) begin
      $display("FAIL prio_opaque_half: got %h, want FFFF00", rgb_now());
      errors++;
    end
  endtask

  task automatic test_blank();
    set_spr(1, 0, 0, 1'b0, 2'd0);
    set_spr(0, 100, 100, 1'b1, 2'd0);
    drive(104, 104, 1'b1, 24'h222222, 1'b0);
    step();
    step();
    step();
    drive(104, 104, 1'b0, 24'h222222, 1'b0);
    step();
    idle();
    step();
    step();
    vectors++;
    if (rgb_now() !== 24'h000000 || bus.blank_out !== 1'b0) begin
      $display("FAIL blanked: got %h/%b, want 000000/0", rgb_now(), bus.blank_out);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int   xs [7];
    rgb24 exp [7];
    xs  = '{1018, 1019, 1020, 1021, 1022, 1023, 0};
    exp = '{24'h200000, 24'h200001, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h200006};
    set_spr(0, 0, 0, 1'b0, 2'd0);
    set_spr(1, 1020, 200, 1'b1, 2'd2);
    for (int s = 1; s <= 9; s++) begin
      if (s <= 7) drive(xs[s-1], 205, 1'b1, 24'h200000 + 24'(s - 1), 1'b0);
      else idle();
      step();
      if (s >= 3) begin
        vectors++;
        if (rgb_now() !== exp[s-3] || bus.blank_out !== 1'b1) begin
          $display("FAIL edge_clip x=%0d: got %h/%b, want %h/1", xs[s-3], rgb_now(), bus.blank_out, exp[s-3]);
          errors++;
        end
      end
    end
    set_spr(1, 0, 0, 1'b0, 2'd0);
    idle();
    step();
  endtask

  task automatic test_collision();
    logic [2:0] exp_old;
    logic [2:0] exp_hit;
    logic       exp_v;
`ifdef SPRITE_COLLISION_EN
    exp_old = 3'b001;
    exp_hit = 3'b010;
    exp_v   = 1'b1;
`else
    exp_old = 3'b000;
    exp_hit = 3'b000;
    exp_v   = 1'b0;
`endif
    set_spr(0, 50, 50, 1'b1, 2'd0);
    set_spr(2, 50, 50, 1'b1, 2'd2);
    // Boundary pixel is itself an overlap: it belongs to the new frame.
    pixel(55, 55, 1'b1, 24'h333333, 1'b1);
    vectors++;
    if (bus.collide !== exp_old || bus.collide_valid !== exp_v) begin
      $display("FAIL coll_prev_frame: got %b/%b, want %b/%b", bus.collide, bus.collide_valid, exp_old, exp_v);
      errors++;
    end
    step();
    vectors++;
    if (bus.collide_valid !== 1'b0 || bus.collide !== exp_old) begin
      $display("FAIL coll_pulse_width: got %b/%b, want %b/0", bus.collide, bus.collide_valid, exp_old);
      errors++;
    end
    pixel(0, 0, 1'b0, 24'h000000, 1'b1);
    vectors++;
    if (bus.collide !== exp_hit || bus.collide_valid !== exp_v) begin
      $display("FAIL coll_overlap: got %b/%b, want %b/%b", bus.collide, bus.collide_valid, exp_hit, exp_v);
      errors++;
    end
    pixel(300, 300, 1'b1, 24'h000000, 1'b0);
    pixel(0, 0, 1'b0, 24'h000000, 1'b1);
    vectors++;
    if (bus.collide !== 3'b000 || bus.collide_valid !== exp_v) begin
      $display("FAIL coll_clear: got %b/%b, want 000/%b", bus.collide, bus.collide_valid, exp_v);
      errors++;
    end
    set_spr(2, 0, 0, 1'b0, 2'd0);
  endtask

  task automatic test_reset_mid();
    set_spr(0, 100, 100, 1'b1, 2'd0);
    drive(104, 104, 1'b1, 24'h444444, 1'b0);
    step();
    step();
    step();
    vectors++;
    if (rgb_now() !== 24'hFFFF00) begin
      $display("FAIL pre_reset: got %h, want FFFF00", rgb_now());
      errors++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rgb_now() !== 24'h000000 || bus.blank_out !== 1'b0 || bus.collide !== 3'b000 || bus.collide_valid !== 1'b0) begin
      $display("FAIL reset_async: got %h/%b/%b/%b, want 000000/0/000/0", rgb_now(), bus.blank_out, bus.collide, bus.collide_valid);
      errors++;
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    vectors++;
    if (rgb_now() !== 24'h000000 || bus.blank_out !== 1'b0) begin
      $display("FAIL resume_early: got %h/%b, want 000000/0", rgb_now(), bus.blank_out);
      errors++;
    end
    step();
    vectors++;
    if (rgb_now() !== 24'hFFFF00 || bus.blank_out !== 1'b1 || bus.collide !== 3'b000) begin
      $display("FAIL resume_3: got %h/%b/%b, want FFFF00/1/000", rgb_now(), bus.blank_out, bus.collide);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_palette();
    test_priority();
    test_blank();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end

endmodule
